// File: rtl/ex_multdiv.sv
// Iterative signed multiply/divide unit for the execute stage.
// One shift-add or restoring-divide step per clock; stalls upstream while busy.
module ex_multdiv #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 ctrl_mult,
    input  logic                 ctrl_div,
    input  logic [WIDTH-1:0]     operandA,
    input  logic [WIDTH-1:0]     operandB,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 stall,
    output logic                 data_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 exception,
    output logic [TAG_WIDTH-1:0] tag_out
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e               stateQ, stateD;
    logic [CntW-1:0]      counterQ;
    logic [WIDTH-1:0]     accQ;      // product high half / partial remainder
    logic [WIDTH-1:0]     loQ;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]     opQ;       // multiplicand or divisor magnitude
    logic                 negQ;
    logic [TAG_WIDTH-1:0] tagQ;

    logic                 lastIter;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH-1:0]     mulAcc, mulLo;
    logic [2*WIDTH-1:0]   product, signedProd;
    logic                 mulExc;
    logic [WIDTH:0]       divShift;
    logic                 divFits;
    logic [WIDTH-1:0]     divRem, divQuo, signedQuo;
    logic                 divExc;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        lastIter   = (counterQ == CntW'(WIDTH - 1));
        mulSum     = {1'b0, accQ} + {1'b0, (loQ[0] ? opQ : '0)};
        mulAcc     = mulSum[WIDTH:1];
        mulLo      = {mulSum[0], loQ[WIDTH-1:1]};
        product    = {mulAcc, mulLo};
        signedProd = negQ ? -product : product;
        mulExc     = signedProd[2*WIDTH-1:WIDTH] != {WIDTH{signedProd[WIDTH-1]}};
        divShift   = {accQ, loQ[WIDTH-1]};
        divFits    = divShift >= {1'b0, opQ};
        // When the trial subtraction fits, the true remainder is below opQ and fits WIDTH bits.
        divRem     = divFits ? (divShift[WIDTH-1:0] - opQ) : divShift[WIDTH-1:0];
        divQuo     = {loQ[WIDTH-2:0], divFits};
        signedQuo  = negQ ? -divQuo : divQuo;
        divExc     = ~negQ & divQuo[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (ctrl_mult) begin
                    stateD = StMult;
                end else if (ctrl_div) begin
                    stateD = (operandB != '0) ? StDiv : StDone;
                end
            end
            StMult:  if (lastIter) stateD = StDone;
            StDiv:   if (lastIter) stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        stall      = clear_n & (((stateQ == StIdle) & (ctrl_mult | ctrl_div)) |
                                (stateQ == StMult) | (stateQ == StDiv));
        data_ready = clear_n & (stateQ == StDone);
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            counterQ  <= '0;
            accQ      <= '0;
            loQ       <= '0;
            opQ       <= '0;
            negQ      <= 1'b0;
            tagQ      <= '0;
            result    <= '0;
            exception <= 1'b0;
            tag_out   <= '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (ctrl_mult || (ctrl_div && operandB != '0)) begin
                        counterQ <= '0;
                        accQ     <= '0;
                        loQ      <= ctrl_mult ? magnitude(operandB) : magnitude(operandA);
                        opQ      <= ctrl_mult ? magnitude(operandA) : magnitude(operandB);
                        negQ     <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                        tagQ     <= tag_in;
                    end else if (ctrl_div) begin
                        result    <= '0;
                        exception <= 1'b1;
                        tag_out   <= tag_in;
                    end
                end
                StMult: begin
                    accQ     <= mulAcc;
                    loQ      <= mulLo;
                    counterQ <= counterQ + CntW'(1);
                    if (lastIter) begin
                        result    <= signedProd[WIDTH-1:0];
                        exception <= mulExc;
                        tag_out   <= tagQ;
                    end
                end
                StDiv: begin
                    accQ     <= divRem;
                    loQ      <= divQuo;
                    counterQ <= counterQ + CntW'(1);
                    if (lastIter) begin
                        result    <= signedQuo;
                        exception <= divExc;
                        tag_out   <= tagQ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
